// File: rtl/jedro_1_regcheck_ctrl.sv
// Sequencer that resets a core, lets it run until an illegal instruction or a
// cycle budget expires, drains it, then compares selected registers against expected values.
module jedro_1_regcheck_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_CHECKS   = 4,
    parameter int MAX_CYCLES   = 32,
    parameter int RESET_CYCLES = 3,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic                                       start_i,
    input  logic                                       illegal_instr_i,
    output logic                                       core_rstn_o,
    output logic [4:0]                                 rf_raddr_o,
    input  logic [DATA_WIDTH-1:0]                      rf_rdata_i,
    input  logic [NUM_CHECKS*5-1:0]                    exp_addr_i,
    input  logic [NUM_CHECKS*DATA_WIDTH-1:0]           exp_data_i,
    output logic                                       busy_o,
    output logic                                       done_o,
    output logic                                       pass_o,
    output logic                                       timeout_o,
    output logic [$clog2(NUM_CHECKS+1)-1:0]            fail_cnt_o,
    output logic [((NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1)-1:0] first_fail_idx_o
);

    localparam int FC_W    = $clog2(NUM_CHECKS + 1);
    localparam int IDX_W   = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
    localparam int CNT_MAX = (MAX_CYCLES > RESET_CYCLES)
                             ? ((MAX_CYCLES > DRAIN_CYCLES) ? MAX_CYCLES : DRAIN_CYCLES)
                             : ((RESET_CYCLES > DRAIN_CYCLES) ? RESET_CYCLES : DRAIN_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD_RST,
        S_RUN,
        S_DRAIN,
        S_CHECK,
        S_DONE
    } state_e;

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   core_rstn_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   pass_q;
    logic                   timeout_q;
    logic [FC_W-1:0]        fail_cnt_q;
    logic [FC_W-1:0]        fail_cnt_d;
    logic [IDX_W-1:0]       first_fail_q;
    logic [DATA_WIDTH-1:0]  exp_data_cur;
    logic                   mismatch;

    // The register file answers combinationally, so the compare happens in the addressing cycle.
    always_comb begin
        exp_data_cur = exp_data_i[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH];
        mismatch     = (state_q == S_CHECK) && (rf_rdata_i != exp_data_cur);
        fail_cnt_d   = fail_cnt_q;
        if (mismatch && (fail_cnt_q != FC_W'(NUM_CHECKS)))
            fail_cnt_d = fail_cnt_q + 1'b1;
        rf_raddr_o = 5'd0;
        if (state_q == S_CHECK)
            rf_raddr_o = exp_addr_i[int'(idx_q)*5 +: 5];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            core_rstn_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            fail_cnt_q   <= '0;
            first_fail_q <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_q      <= S_HOLD_RST;
                        cnt_q        <= '0;
                        core_rstn_q  <= 1'b0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        timeout_q    <= 1'b0;
                        fail_cnt_q   <= '0;
                        first_fail_q <= '0;
                    end
                end
                S_HOLD_RST: begin
                    if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
                        state_q     <= S_RUN;
                        cnt_q       <= '0;
                        core_rstn_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    // An illegal instruction in the final budget cycle counts as a clean stop.
                    if (illegal_instr_i || (cnt_q == CNT_W'(MAX_CYCLES - 1))) begin
                        state_q   <= S_DRAIN;
                        cnt_q     <= '0;
                        timeout_q <= !illegal_instr_i;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
                        state_q <= S_CHECK;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_CHECK: begin
                    fail_cnt_q <= fail_cnt_d;
                    if (mismatch && (fail_cnt_q == '0))
                        first_fail_q <= idx_q;
                    if (idx_q == IDX_W'(NUM_CHECKS - 1)) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (fail_cnt_d == '0) && !timeout_q;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign core_rstn_o      = core_rstn_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign timeout_o        = timeout_q;
    assign fail_cnt_o       = fail_cnt_q;
    assign first_fail_idx_o = first_fail_q;

endmodule

// File: tb/tb_jedro_1_regcheck_ctrl.sv
// Randomized scoreboard bench for jedro_1_regcheck_ctrl with a register-file model
// and a reference model of the expected result and start-to-done latency.
module tb_jedro_1_regcheck_ctrl;

    localparam int DW   = 32;
    localparam int NC   = 4;
    localparam int MAXC = 32;
    localparam int RSTC = 3;
    localparam int DRC  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_i;
    logic              illegal_instr_i;
    logic              core_rstn_o;
    logic [4:0]        rf_raddr_o;
    logic [DW-1:0]     rf_rdata_i;
    logic [NC*5-1:0]   exp_addr_i;
    logic [NC*DW-1:0]  exp_data_i;
    logic              busy_o, done_o, pass_o, timeout_o;
    logic [2:0]        fail_cnt_o;
    logic [1:0]        first_fail_idx_o;

    logic [DW-1:0] rf [32];
    logic [4:0]    ea [NC];
    logic [DW-1:0] ed [NC];

    typedef struct {
        int   lat;
        logic pss;
        int   fc;
        int   fi;
        logic to;
        int   sc;
    } exp_t;
    exp_t sb_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    jedro_1_regcheck_ctrl #(
        .DATA_WIDTH(DW), .NUM_CHECKS(NC), .MAX_CYCLES(MAXC),
        .RESET_CYCLES(RSTC), .DRAIN_CYCLES(DRC)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start_i), .illegal_instr_i(illegal_instr_i),
        .core_rstn_o(core_rstn_o), .rf_raddr_o(rf_raddr_o), .rf_rdata_i(rf_rdata_i),
        .exp_addr_i(exp_addr_i), .exp_data_i(exp_data_i), .busy_o(busy_o),
        .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
        .fail_cnt_o(fail_cnt_o), .first_fail_idx_o(first_fail_idx_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;
    assign rf_rdata_i = rf[rf_raddr_o];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic pack_entries();
        for (int k = 0; k < NC; k++) begin
            exp_addr_i[5*k +: 5]   = ea[k];
            exp_data_i[DW*k +: DW] = ed[k];
        end
    endtask

    // Reference model: what the finished sequence must report, from the entry tables and register file.
    function automatic exp_t model(input int ill_at, input int sc);
        exp_t e;
        int   fails = 0;
        int   first = 0;
        int   last;
        for (int k = 0; k < NC; k++)
            if (rf[ea[k]] != ed[k]) begin
                if (fails == 0) first = k;
                fails++;
            end
        e.to  = !(ill_at >= 0 && ill_at <= MAXC - 1);
        last  = e.to ? MAXC - 1 : ill_at;
        e.lat = RSTC + (last + 1) + DRC + NC;
        e.fc  = (fails > NC) ? NC : fails;
        e.fi  = first;
        e.pss = (fails == 0) && !e.to;
        e.sc  = sc;
        return e;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_core_rstn"}, int'(core_rstn_o), 0);
        chk({tag, "_busy"},      int'(busy_o), 0);
        chk({tag, "_done"},      int'(done_o), 0);
        chk({tag, "_pass"},      int'(pass_o), 0);
        chk({tag, "_timeout"},   int'(timeout_o), 0);
        chk({tag, "_fail_cnt"},  int'(fail_cnt_o), 0);
        chk({tag, "_first_idx"}, int'(first_fail_idx_o), 0);
        chk({tag, "_raddr"},     int'(rf_raddr_o), 0);
    endtask

    // ill_at: RUN counter value at which illegal_instr_i pulses (-1 = never).
    task automatic run_seq(input int ill_at, input bit start_in_run, input bit abort);
        exp_t e;
        int   last;
        bit   got = 0;
        last = (ill_at >= 0 && ill_at <= MAXC - 1) ? ill_at : MAXC - 1;
        pack_entries();
        @(negedge clk);
        start_i = 1'b1;
        e = model(ill_at, cyc);
        if (!abort) sb_q.push_back(e);
        @(negedge clk);
        start_i = 1'b0;
        for (int k = 1; k <= 250; k++) begin
            if (k <= RSTC) begin
                chk("hold_core_rstn", int'(core_rstn_o), 0);
                chk("hold_busy", int'(busy_o), 1);
                chk("hold_done", int'(done_o), 0);
            end
            if (k == RSTC + 1) chk("run_core_rstn", int'(core_rstn_o), 1);
            illegal_instr_i = (ill_at >= 0) && (k == RSTC + 1 + ill_at);
            start_i = start_in_run && (last >= 2) && (k == RSTC + 3);
            if (abort && k == RSTC + last + 3) begin
                illegal_instr_i = 1'b0;
                start_i = 1'b0;
                rst = 1'b1;
                #1;
                chk_reset_vals("abort");
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                repeat (4) @(negedge clk);
                chk("post_abort_idle_busy", int'(busy_o), 0);
                chk("post_abort_idle_rstn", int'(core_rstn_o), 0);
                return;
            end
            if (done_o) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        illegal_instr_i = 1'b0;
        start_i = 1'b0;
        if (!got) chk("done_wait_expired", 0, 1);
    endtask

    // Monitor: pops the expected result whenever done_o rises.
    initial begin
        logic done_prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (done_o && !done_prev) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("latency",   cyc - e.sc - 1, e.lat);
                    chk("pass",      int'(pass_o), int'(e.pss));
                    chk("timeout",   int'(timeout_o), int'(e.to));
                    chk("fail_cnt",  int'(fail_cnt_o), e.fc);
                    chk("first_idx", int'(first_fail_idx_o), e.fi);
                    chk("done_busy", int'(busy_o), 0);
                    chk("done_raddr", int'(rf_raddr_o), 0);
                    chk("done_rstn", int'(core_rstn_o), 1);
                end
            end
            done_prev = done_o;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start_i = 1'b0;
        illegal_instr_i = 1'b0;
        exp_addr_i = '0;
        exp_data_i = '0;
        for (int i = 0; i < 32; i++) rf[i] = '0;
        for (int k = 0; k < NC; k++) begin
            ea[k] = '0;
            ed[k] = '0;
        end
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_wait_busy", int'(busy_o), 0);

        rf[0] = 32'h0;
        rf[1] = 32'h8000_1000;
        rf[2] = 32'h8000_2004;
        rf[3] = 32'h8000_3008;
        ea[0] = 5'd1; ed[0] = 32'h8000_1000;
        ea[1] = 5'd2; ed[1] = 32'h8000_2004;
        ea[2] = 5'd3; ed[2] = 32'h8000_3008;
        ea[3] = 5'd0; ed[3] = 32'h0;
        run_seq(10, 0, 0);
        rf[2] = 32'h8000_2000;
        rf[3] = 32'h0;
        run_seq(10, 0, 0);
        rf[2] = 32'h8000_2004;
        rf[3] = 32'h8000_3008;
        run_seq(-1, 0, 0);
        run_seq(MAXC - 1, 0, 0);
        run_seq(12, 1, 0);
        run_seq(5, 0, 1);
        run_seq(7, 0, 0);

        for (int r = 0; r < 16; r++) begin
            int ill;
            for (int i = 0; i < 32; i++) rf[i] = $urandom;
            for (int k = 0; k < NC; k++) begin
                ea[k] = 5'($urandom_range(0, 31));
                ed[k] = ($urandom_range(0, 2) == 0) ? $urandom : rf[ea[k]];
            end
            ill = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 38));
            run_seq(ill, ($urandom_range(0, 3) == 0), 0);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jedro_1_regcheck_ctrl.md
JEDRO_1_REGCHECK_CTRL -- requirements
Module: jedro_1_regcheck_ctrl

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- DATA_WIDTH, 32: register width.
- NUM_CHECKS, 4: number of register/expected-value pairs.
- MAX_CYCLES, 32: RUN-state cycle budget.
- RESET_CYCLES, 3: core reset hold length.
- DRAIN_CYCLES, 3: pipeline drain length.
REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clk_i, in, 1: the single clock.
- rst_i, in, 1: reset; asynchronous, active-high.
- start_i, in, 1: single-cycle start pulse.
- illegal_instr_i, in, 1: core decoder illegal-instruction flag.
- core_rstn_o, out, 1: active-low reset to the core under test.
- rf_raddr_o, out, 5: register-file debug read address.
- rf_rdata_i, in, DATA_WIDTH: combinational register-file read data.
- exp_addr_i, in, NUM_CHECKS*5: packed register indices; entry k at bits [5k+4:5k].
- exp_data_i, in, NUM_CHECKS*DATA_WIDTH: packed expected values; entry k at bits [DATA_WIDTH*k +: DATA_WIDTH].
- busy_o, out, 1: a sequence is in progress.
- done_o, out, 1: the sequence is complete.
- pass_o, out, 1: all checks matched and no timeout occurred.
- timeout_o, out, 1: the cycle budget expired without an illegal instruction.
- fail_cnt_o, out, $clog2(NUM_CHECKS+1): number of mismatching entries.
- first_fail_idx_o, out, $clog2(NUM_CHECKS) (min 1): index of the lowest-numbered mismatching entry.

Function
REQ-003 The block SHALL implement the states IDLE, HOLD_RST, RUN, DRAIN, CHECK and DONE.
REQ-004 IDLE: start_i=1 SHALL move to HOLD_RST on the next edge and clear all result outputs.
REQ-005 HOLD_RST: core_rstn_o SHALL be 0 for exactly RESET_CYCLES cycles, then the state SHALL move to RUN.
REQ-006 core_rstn_o SHALL be 0 in IDLE and HOLD_RST, and 1 in RUN, DRAIN, CHECK and DONE, so that registers stay readable after completion.
REQ-007 RUN: a cycle counter SHALL start at 0 and increment each cycle. The state SHALL exit to DRAIN on the edge where illegal_instr_i=1 or the counter equals MAX_CYCLES-1.
REQ-008 timeout_o SHALL be set on RUN exit only when the counter reached MAX_CYCLES-1 and illegal_instr_i=0 in that same cycle; if both occur in the same cycle, timeout_o SHALL stay 0.
REQ-009 DRAIN SHALL last exactly DRAIN_CYCLES cycles, then move to CHECK with the index at 0.
REQ-010 CHECK: each cycle SHALL drive rf_raddr_o = exp_addr_i entry[idx] and compare rf_rdata_i with exp_data_i entry[idx] in that same cycle. One entry SHALL be checked per cycle, so CHECK lasts NUM_CHECKS cycles.
REQ-011 On a mismatch, fail_cnt_o SHALL increment, saturating at NUM_CHECKS. first_fail_idx_o SHALL latch idx only on the first mismatch.
REQ-012 After the last index, the state SHALL move to DONE. In the cycle of entry to DONE, done_o SHALL be set to 1 and pass_o SHALL be set to (fail_cnt==0 && !timeout), both registered.
REQ-013 DONE SHALL hold done_o, pass_o, fail_cnt_o, first_fail_idx_o and timeout_o stable. start_i SHALL restart the sequence via HOLD_RST and clear the results.
REQ-014 busy_o SHALL be 1 in HOLD_RST, RUN, DRAIN and CHECK, and 0 in IDLE and DONE.
REQ-015 start_i SHALL be ignored while busy_o=1.
REQ-016 rf_raddr_o SHALL be 0 outside CHECK.
REQ-017 Index 0 entries SHALL be compared like any other entry; the block SHALL NOT special-case x0.
REQ-018 All outputs SHALL be registered except rf_raddr_o, which is decoded from the state and index.

Reset
REQ-019 On rst_i=1, asynchronously:
- state = IDLE;
- core_rstn_o = 0;
- busy_o, done_o, pass_o and timeout_o = 0;
- fail_cnt_o and first_fail_idx_o = 0;
- rf_raddr_o = 0.
REQ-020 Reset asserted mid-sequence SHALL abort the sequence with no partial result retained. After reset is released, the block SHALL remain in IDLE until start_i.

Verification
REQ-021 Scenario: expected entries x1=0x80001000, x2=0x80002004, x3=0x80003008, x0=0; model register file matches; illegal_instr_i pulses at RUN cycle 10 -> done_o=1 with pass_o=1, fail_cnt_o=0, timeout_o=0, exactly 3+11+3+4 cycles after start.
REQ-022 Scenario: same setup, but x2 reads 0x80002000 and x3 reads 0 -> pass_o=0, fail_cnt_o=2, first_fail_idx_o=1.
REQ-023 Scenario: illegal_instr_i never asserts, all values match -> RUN lasts 32 cycles, timeout_o=1, pass_o=0, fail_cnt_o=0.
REQ-024 Scenario: illegal_instr_i rises exactly at RUN counter 31 -> timeout_o=0.
REQ-025 Scenario: rst_i asserted during DRAIN -> all outputs return to reset values immediately; a later start_i runs a full sequence and produces a correct result.
REQ-026 Scenario: start_i pulsed during RUN -> ignored with no change in timing; start_i pulsed in DONE -> done_o clears and core_rstn_o drops for 3 cycles.
